// File: rtl/alu_dispatch_if.sv
// Dispatch-side bus: instruction handshake, ALU operand/result path and
// writeback report. master = fetch/ALU side, slave = alu_dispatch.
interface alu_dispatch_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         instr_valid;
    logic                         instr_ready;
    logic [15:0]                  instr;
    logic [2:0]                   alu_op;
    logic signed [DATA_WIDTH-1:0] alu_lhs;
    logic signed [DATA_WIDTH-1:0] alu_rhs;
    logic [DATA_WIDTH-1:0]        alu_result;
    logic                         wb_valid;
    logic [2:0]                   wb_rd;
    logic [DATA_WIDTH-1:0]        wb_data;

    modport master (
        output instr_valid, instr, alu_result,
        input  instr_ready, alu_op, alu_lhs, alu_rhs, wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  instr_valid, instr, alu_result,
        output instr_ready, alu_op, alu_lhs, alu_rhs, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/alu_dispatch.sv
// alu_dispatch: accepts instruction words, reads an 8-entry register file,
// drives a registered op/lhs/rhs to an external ALU and writes the result back.
// One op in flight, IDLE->DECODE->EXECUTE->WRITEBACK, a new op may be accepted
// in WRITEBACK. Optional build macro DISPATCH_FLAGS_EN adds zero/negative flags.
module alu_dispatch #(
    parameter int DATA_WIDTH = 16,
    parameter int IMM_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_dispatch_if.slave         bus,
    input  logic                  i_ld_en,
    input  logic [2:0]            i_ld_addr,
    input  logic [DATA_WIDTH-1:0] i_ld_data,
    input  logic [2:0]            i_dbg_addr,
    output logic [DATA_WIDTH-1:0] o_dbg_data,
    output logic                  o_busy
`ifdef DISPATCH_FLAGS_EN
    ,
    output logic                  o_flag_z,
    output logic                  o_flag_n
`endif
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_ready;
    logic                  w_accept;
    logic [15:0]           r_instr;
    logic [DATA_WIDTH-1:0] r_regs [8];
    logic [2:0]            r_alu_op;
    logic [DATA_WIDTH-1:0] r_alu_lhs;
    logic [DATA_WIDTH-1:0] r_alu_rhs;
    logic                  r_wb_valid;
    logic [2:0]            r_wb_rd;
    logic [DATA_WIDTH-1:0] r_wb_data;

    // Instruction fields of the latched word
    logic [2:0]            w_op, w_rd, w_rs1, w_rs2;
    logic                  w_imm_sel;
    logic [DATA_WIDTH-1:0] w_imm_sext;
    logic [DATA_WIDTH-1:0] w_rs1_val, w_rs2_val;

    assign w_op       = r_instr[15:13];
    assign w_rd       = r_instr[12:10];
    assign w_rs1      = r_instr[9:7];
    assign w_imm_sel  = r_instr[6];
    assign w_rs2      = r_instr[5:3];
    assign w_imm_sext = {{(DATA_WIDTH-IMM_WIDTH){r_instr[IMM_WIDTH-1]}}, r_instr[IMM_WIDTH-1:0]};
    // r0 reads as zero regardless of storage contents
    assign w_rs1_val  = (w_rs1 == 3'd0) ? '0 : r_regs[w_rs1];
    assign w_rs2_val  = (w_rs2 == 3'd0) ? '0 : r_regs[w_rs2];
    assign w_accept   = bus.instr_valid && w_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state: fixed 3-cycle walk, WRITEBACK may chain straight into DECODE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_accept) w_next = DECODE;
            DECODE:    w_next = EXECUTE;
            EXECUTE:   w_next = WRITEBACK;
            WRITEBACK: w_next = w_accept ? DECODE : IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_ready = (r_state == IDLE) || (r_state == WRITEBACK);
        o_busy  = (r_state != IDLE);
    end

    // Latch the instruction word on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_instr <= '0;
        else if (w_accept) r_instr <= bus.instr;
    end

    // Operand fetch in DECODE; held otherwise so the ALU inputs stay quiet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_op  <= '0;
            r_alu_lhs <= '0;
            r_alu_rhs <= '0;
        end else if (r_state == DECODE) begin
            r_alu_op  <= w_op;
            r_alu_lhs <= w_rs1_val;
            r_alu_rhs <= w_imm_sel ? w_imm_sext : w_rs2_val;
        end
    end

    // Capture ALU result at end of EXECUTE; this register is also wb_data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= (r_state == EXECUTE);
            if (r_state == EXECUTE) begin
                r_wb_rd   <= w_rd;
                r_wb_data <= bus.alu_result;
            end
        end
    end

    // Register file: preload first, writeback last so it wins on a collision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
        end else begin
            if (i_ld_en && i_ld_addr != 3'd0)
                r_regs[i_ld_addr] <= i_ld_data;
            if (r_state == WRITEBACK && r_wb_rd != 3'd0)
                r_regs[r_wb_rd] <= r_wb_data;
        end
    end

`ifdef DISPATCH_FLAGS_EN
    // Flags follow each written-back result, including r0 destinations
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_flag_z <= 1'b0;
            o_flag_n <= 1'b0;
        end else if (r_state == EXECUTE) begin
            o_flag_z <= (bus.alu_result == '0);
            o_flag_n <= bus.alu_result[DATA_WIDTH-1];
        end
    end
`endif

    assign o_dbg_data      = (i_dbg_addr == 3'd0) ? '0 : r_regs[i_dbg_addr];
    assign bus.instr_ready = w_ready;
    assign bus.alu_op      = r_alu_op;
    assign bus.alu_lhs     = r_alu_lhs;
    assign bus.alu_rhs     = r_alu_rhs;
    assign bus.wb_valid    = r_wb_valid;
    assign bus.wb_rd       = r_wb_rd;
    assign bus.wb_data     = r_wb_data;
endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: behavioural ALU closes the loop, a sequential
// register-file model predicts every writeback, a monitor checks them.
module tb_alu_dispatch;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ld_en = 1'b0;
    logic [2:0]    ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic [2:0]    dbg_addr = '0;
    logic [DW-1:0] dbg_data;
    logic          busy;
`ifdef DISPATCH_FLAGS_EN
    logic          flag_z, flag_n;
`endif

    alu_dispatch_if #(.DATA_WIDTH(DW)) bus ();

    alu_dispatch #(.DATA_WIDTH(DW), .IMM_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
        .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data), .o_busy(busy)
`ifdef DISPATCH_FLAGS_EN
        , .o_flag_z(flag_z), .o_flag_n(flag_n)
`endif
    );

    always #5 clk = ~clk;

    // Bench ALU: one distinct function per op code
    function automatic logic [DW-1:0] alu_fn(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a ^ b;
            3'd3: return a | b;
            3'd4: return a << b[3:0];
            3'd5: return a & b;
            3'd6: return $unsigned($signed(a) >>> b[3:0]);
            default: return {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
        endcase
    endfunction

    assign bus.alu_result = alu_fn(bus.alu_op, bus.alu_lhs, bus.alu_rhs);

    typedef struct { logic [2:0] rd; logic [DW-1:0] data; int cyc; } exp_t;
    exp_t          expq[$];
    logic [DW-1:0] mregs [8];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mk(input int op, input int rd, input int rs1, input int isel, input int low6);
        return {op[2:0], rd[2:0], rs1[2:0], isel[0], low6[5:0]};
    endfunction

    // Monitor: every wb pulse must match the oldest prediction
    always @(negedge clk) begin
        if (!rst && bus.wb_valid) begin
            if (expq.size() == 0) begin
                chk("unexpected_wb", 32'(bus.wb_rd), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
                chk("wb_data", 32'(bus.wb_data), 32'(e.data));
                chk("wb_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Sequential reference: an op reads then writes the model at issue order
    task automatic model_issue(input logic [15:0] w, input int acc_cyc);
        exp_t e;
        logic [DW-1:0] a, b;
        a = mregs[w[9:7]];
        b = w[6] ? {{(DW-6){w[5]}}, w[5:0]} : mregs[w[5:3]];
        e.rd   = w[12:10];
        e.data = alu_fn(w[15:13], a, b);
        e.cyc  = acc_cyc + 3;
        if (e.rd != 3'd0) mregs[e.rd] = e.data;
        expq.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic [15:0] w, output int acc_cyc);
        int n = 0;
        bit acc = 0;
        acc_cyc = -1;
        bus.instr_valid = 1'b1;
        bus.instr = w;
        while (!acc && n < 20) begin
            if (bus.instr_ready) begin
                acc = 1;
                acc_cyc = cyc;
                model_issue(w, cyc);
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        bus.instr_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic preload(input logic [2:0] a, input logic [DW-1:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk);
        @(negedge clk);
        ld_en = 1'b0;
        if (a != 3'd0) mregs[a] = d;
    endtask

    task automatic chk_dbg(input string name, input logic [2:0] a, input logic [DW-1:0] exp);
        dbg_addr = a;
        #1;
        chk(name, 32'(dbg_data), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c2;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        for (int i = 0; i < 8; i++) mregs[i] = '0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_ready", 32'(bus.instr_ready), 32'd1);
        chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: AND r3 = r1 & r2
        preload(3'd1, 16'd12);
        preload(3'd2, 16'd10);
        issue(mk(5, 3, 1, 0, 2 << 3), c1);
        wait_idle();
        chk_dbg("dbg_r3_and", 3'd3, 16'd8);

        // 2: immediate forms, positive and sign-extended negative
        issue(mk(5, 4, 1, 1, 6), c1);
        wait_idle();
        chk_dbg("dbg_r4_imm", 3'd4, 16'd4);
        issue(mk(5, 5, 1, 1, 6'h3D), c1);
        wait_idle();
        chk_dbg("dbg_r5_negimm", 3'd5, 16'd12);

        // 3: back-to-back dependent ops, second accepted in WRITEBACK
        issue(mk(5, 3, 1, 0, 2 << 3), c1);
        issue(mk(5, 6, 3, 1, 0), c2);
        chk("b2b_accept_gap", 32'(c2 - c1), 32'd3);
        wait_idle();
        chk_dbg("dbg_r6_zero", 3'd6, 16'd0);

        // 4: r0 destination and r0 preload are discarded
        issue(mk(0, 0, 1, 0, 2 << 3), c1);
        wait_idle();
        chk_dbg("dbg_r0_wb", 3'd0, 16'd0);
        preload(3'd0, 16'h1234);
        chk_dbg("dbg_r0_ld", 3'd0, 16'd0);

        // 5: preload collides with writeback to the same register
        preload(3'd3, 16'd0);
        issue(mk(5, 3, 1, 0, 2 << 3), c1);
        @(negedge clk);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 3'd3; ld_data = 16'd7;
        @(posedge clk);
        @(negedge clk);
        ld_en = 1'b0;
        wait_idle();
        chk_dbg("dbg_r3_wb_wins", 3'd3, 16'd8);

        // Randomized mix of ops, preloads and idle gaps
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                wait_idle();
                preload(3'($urandom_range(0, 7)), 16'($urandom));
            end
            if ($urandom_range(0, 2) == 0) wait_idle();
            issue(16'($urandom), c1);
        end
        wait_idle();
        @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        for (int i = 0; i < 8; i++) chk_dbg("dbg_final", 3'(i), mregs[i]);

        // 6: reset during EXECUTE drops the in-flight op
        preload(3'd1, 16'h00F0);
        issue(mk(3, 2, 1, 1, 5), c1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("midrst_alu_op", 32'(bus.alu_op), 32'd0);
        chk("midrst_alu_lhs", 32'(bus.alu_lhs), 32'd0);
        chk("midrst_alu_rhs", 32'(bus.alu_rhs), 32'd0);
        expq.delete();
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 8; i++) chk_dbg("dbg_after_rst", 3'(i), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
